// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/pedestrian bundle for traffic_phase_ctrl.
// The master drives timebase and button; the slave (controller) drives the lamps.
interface traffic_phase_ctrl_if;
    logic       tick_en;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick_en,
        output ped_req,
        input  ns_light,
        input  ew_light,
        input  walk,
        input  ped_pending,
        input  phase
    );

    modport slave (
        input  tick_en,
        input  ped_req,
        output ns_light,
        output ew_light,
        output walk,
        output ped_pending,
        output phase
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: NS/EW green-yellow-allred with walk insertion.
// Owns the phase timer; lamps are registered one cycle behind the state.
module traffic_phase_ctrl #(
    parameter int unsigned GREEN_TICKS  = 45,
    parameter int unsigned YELLOW_TICKS = 9,
    parameter int unsigned ALLRED_TICKS = 3,
    parameter int unsigned WALK_TICKS   = 15,
    parameter int unsigned CNT_W        = 6
) (
    input  logic                 clk_out,
    input  logic                 reset,
    traffic_phase_ctrl_if.slave  bus
);

    localparam logic [2:0] S_NS_G  = 3'd0;
    localparam logic [2:0] S_NS_Y  = 3'd1;
    localparam logic [2:0] S_AR_A  = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_AR_B  = 3'd5;
    localparam logic [2:0] S_WALK  = 3'd6;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_TICKS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             dir_q, dir_d;
    logic             pend_q, pend_d;
    logic [2:0]       ns_q, ns_d;
    logic [2:0]       ew_q, ew_d;
    logic             walk_q, walk_d;
    logic             phase_end;

    // Timer reload value for the phase being entered.
    function automatic logic [CNT_W-1:0] load_val(input logic [2:0] s);
        logic [CNT_W-1:0] v;
        case (s)
            S_NS_G, S_EW_G: v = LD_GREEN;
            S_NS_Y, S_EW_Y: v = LD_YELLOW;
            S_WALK:         v = LD_WALK;
            default:        v = LD_ALLRED;
        endcase
        return v;
    endfunction

    // State, timer, direction memory and pedestrian latch.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q <= S_AR_A;
            timer_q <= LD_ALLRED;
            dir_q   <= DIR_NS;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    // Next phase, timer update and request latch.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        phase_end = bus.tick_en && (timer_q == '0);
        case (state_q)
            S_NS_G: if (phase_end) state_d = S_NS_Y;
            S_NS_Y: if (phase_end) state_d = S_AR_B;
            S_EW_G: if (phase_end) state_d = S_EW_Y;
            S_EW_Y: if (phase_end) state_d = S_AR_A;
            S_AR_B: begin
                if (phase_end) begin
                    if (pend_q) begin
                        state_d = S_WALK;
                        dir_d   = DIR_EW;
                    end else begin
                        state_d = S_EW_G;
                    end
                end
            end
            S_AR_A: begin
                if (phase_end) begin
                    if (pend_q) begin
                        state_d = S_WALK;
                        dir_d   = DIR_NS;
                    end else begin
                        state_d = S_NS_G;
                    end
                end
            end
            S_WALK: begin
                if (phase_end) begin
                    state_d = (dir_q == DIR_NS) ? S_NS_G : S_EW_G;
                end
            end
            default: state_d = S_AR_A;
        endcase

        if (state_d != state_q) begin
            timer_d = load_val(state_d);
        end else if (bus.tick_en && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Entering the walk serves the request, even one arriving now.
        pend_d = pend_q;
        if (bus.ped_req && (state_q != S_WALK)) begin
            pend_d = 1'b1;
        end
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            pend_d = 1'b0;
        end
    end

    // Lamp decode from the current phase.
    always_comb begin
        ns_d   = L_RED;
        ew_d   = L_RED;
        walk_d = 1'b0;
        case (state_q)
            S_NS_G: ns_d   = L_GREEN;
            S_NS_Y: ns_d   = L_YELLOW;
            S_EW_G: ew_d   = L_GREEN;
            S_EW_Y: ew_d   = L_YELLOW;
            S_WALK: walk_d = 1'b1;
            default: begin
                ns_d   = L_RED;
                ew_d   = L_RED;
                walk_d = 1'b0;
            end
        endcase
    end

    // Registered lamp drivers.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            ns_q   <= L_RED;
            ew_q   <= L_RED;
            walk_q <= 1'b0;
        end else begin
            ns_q   <= ns_d;
            ew_q   <= ew_d;
            walk_q <= walk_d;
        end
    end

    assign bus.ns_light    = ns_q;
    assign bus.ew_light    = ew_q;
    assign bus.walk        = walk_q;
    assign bus.ped_pending = pend_q;
    assign bus.phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a tick-counting phase model.
// Lamp expectations trail the model phase by one clock.
module tb_traffic_phase_ctrl;

    localparam int G  = 45;
    localparam int Y  = 9;
    localparam int AR = 3;
    localparam int W  = 15;

    logic clk_out = 1'b0;
    logic reset   = 1'b0;

    traffic_phase_ctrl_if bus();

    traffic_phase_ctrl #(
        .GREEN_TICKS (G),
        .YELLOW_TICKS(Y),
        .ALLRED_TICKS(AR),
        .WALK_TICKS  (W),
        .CNT_W       (6)
    ) dut (
        .clk_out(clk_out),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_out = ~clk_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: phase, ticks still owed, latch, direction after walk,
    // and the phase currently shown on the lamps.
    int m_phase;
    int m_left;
    int m_lamp;
    bit m_pend;
    bit m_dir_ew;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            0, 3:    return G;
            1, 4:    return Y;
            6:       return W;
            default: return AR;
        endcase
    endfunction

    function automatic logic [2:0] lamp(input int p, input bit ns);
        if (ns) return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
        return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    endfunction

    task automatic model_reset();
        m_phase  = 2;
        m_left   = AR;
        m_lamp   = 2;
        m_pend   = 1'b0;
        m_dir_ew = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit rq);
        int old;
        int nxt;
        old = m_phase;
        nxt = m_phase;
        if (tk) begin
            if (m_left == 1) begin
                case (old)
                    0: nxt = 1;
                    1: nxt = 5;
                    3: nxt = 4;
                    4: nxt = 2;
                    5: begin nxt = m_pend ? 6 : 3; if (m_pend) m_dir_ew = 1'b1; end
                    2: begin nxt = m_pend ? 6 : 0; if (m_pend) m_dir_ew = 1'b0; end
                    default: nxt = m_dir_ew ? 3 : 0;
                endcase
            end else begin
                m_left--;
            end
        end
        if (rq && old != 6) m_pend = 1'b1;
        if (nxt == 6 && old != 6) m_pend = 1'b0;
        if (nxt != old) m_left = dur(nxt);
        m_phase = nxt;
        m_lamp  = old;
    endtask

    task automatic compare_all();
        logic ns_nr;
        logic ew_nr;
        ns_nr = (bus.ns_light != 3'b100);
        ew_nr = (bus.ew_light != 3'b100);
        check("phase", 32'(bus.phase), 32'(m_phase));
        check("phase_range", 32'(bus.phase <= 3'd6), 1);
        check("ped_pending", 32'(bus.ped_pending), 32'(m_pend));
        check("ns_light", 32'(bus.ns_light), 32'(lamp(m_lamp, 1'b1)));
        check("ew_light", 32'(bus.ew_light), 32'(lamp(m_lamp, 1'b0)));
        check("walk", 32'(bus.walk), 32'(m_lamp == 6));
        check("safety_dirs", 32'(ns_nr && ew_nr), 0);
        check("safety_walk", 32'(bus.walk && (ns_nr || ew_nr)), 0);
    endtask

    // Apply inputs for the coming edge, then check after it.
    task automatic cycle(input bit tk, input bit rq);
        bus.tick_en = tk;
        bus.ped_req = rq;
        model_step(tk, rq);
        @(negedge clk_out);
        compare_all();
    endtask

    initial begin
        int ns_g;
        int ns_y;
        int ew_g;
        int walks;
        bit hit;

        bus.tick_en = 1'b0;
        bus.ped_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_out);
        compare_all();
        reset = 1'b1;

        // Free-running timebase: one full period of lamp cycles.
        ns_g = 0; ns_y = 0; ew_g = 0;
        for (int i = 0; i < 114; i++) begin
            cycle(1'b1, 1'b0);
            if (bus.ns_light == 3'b001) ns_g++;
            if (bus.ns_light == 3'b010) ns_y++;
            if (bus.ew_light == 3'b001) ew_g++;
        end
        check("ns_green_len", 32'(ns_g), 45);
        check("ns_yellow_len", 32'(ns_y), 9);
        check("ew_green_len", 32'(ew_g), 45);

        // One strobe in four: phases stretch by four.
        ns_g = 0;
        for (int i = 0; i < 456; i++) begin
            cycle(i % 4 == 3, 1'b0);
            if (bus.ns_light == 3'b001) ns_g++;
        end
        check("ns_green_len_div4", 32'(ns_g), 180);

        // Single request pulse ten ticks into NS green.
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle(1'b1, 1'b0);
            hit = (m_phase == 0 && m_left == G);
        end
        check("reach_ns_green", 32'(hit), 1);
        repeat (10) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("pending_after_pulse", 32'(bus.ped_pending), 1);
        walks = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1'b1, 1'b0);
            if (bus.walk) walks++;
        end
        check("walk_len", 32'(walks), 15);

        // Random timebase and sparse requests.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        // Request held high: a walk after every all-red.
        walks = 0;
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 1'b1);
            if (bus.walk) walks++;
        end
        check("held_walks_nonzero", 32'(walks > 0), 1);

        // Asynchronous reset mid EW yellow with a request waiting.
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle(1'b1, 1'b0);
            hit = (m_phase == 4 && m_left == Y);
        end
        check("reach_ew_yellow", 32'(hit), 1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check("pending_before_rst", 32'(bus.ped_pending), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_phase", 32'(bus.phase), 2);
        check("rst_ns", 32'(bus.ns_light), 32'h4);
        check("rst_ew", 32'(bus.ew_light), 32'h4);
        check("rst_walk", 32'(bus.walk), 0);
        check("rst_pending", 32'(bus.ped_pending), 0);
        model_reset();
        @(negedge clk_out);
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Intersection controller that sequences the traffic lights through the phases green -> yellow -> all-red for two directions, north-south (NS) and east-west (EW).
- Serves pedestrian requests by inserting a walk phase between the two directions.
- Each phase runs for a programmable number of timer ticks. Ticks come from the clock-divided timebase already used by the traffic-light counters.
- Owns the phase timer internally; downstream logic only decodes the registered light outputs.

Parameters:
- GREEN_TICKS, 45, ticks per green phase (>=1)
- YELLOW_TICKS, 9, ticks per yellow phase (>=1)
- ALLRED_TICKS, 3, ticks per all-red clearance phase (>=1)
- WALK_TICKS, 15, ticks per pedestrian walk phase (>=1)
- CNT_W, 6, phase-timer width; must hold max(*_TICKS)-1

Ports:
- clk_out  in  1  system clock (divided clock domain)
- reset  in  1  asynchronous, active-low reset
- tick_en  in  1  timebase strobe; one phase tick per cycle it is high
- ped_req  in  1  pedestrian button, level or pulse; sampled every cycle
- ns_light  out  3  {red,yellow,green} one-hot for NS
- ew_light  out  3  {red,yellow,green} one-hot for EW
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  request latched, not yet served
- phase  out  3  current state code

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ALLRED_A, next_dir=NS, timer=ALLRED_TICKS-1, ped_pending=0.
  - ns_light=ew_light=3'b100, walk=0.
- Phase codes:
  - 0 NS_GREEN, 1 NS_YELLOW, 2 ALLRED_A (before NS/walk), 3 EW_GREEN, 4 EW_YELLOW, 5 ALLRED_B (before EW/walk), 6 PED_WALK.
  - Codes 7 and any other illegal code recover to ALLRED_A on the next clock edge.
- Timer:
  - Loaded with <PHASE>_TICKS-1 on the cycle the state changes.
  - Decrements by 1 only on cycles with tick_en=1.
  - A phase ends on a cycle where timer==0 and tick_en==1, so every phase lasts exactly <PHASE>_TICKS strobes.
  - tick_en=0 freezes state and timer.
- Transitions, taken on the cycle a phase ends:
  - NS_GREEN -> NS_YELLOW -> ALLRED_B.
  - EW_GREEN -> EW_YELLOW -> ALLRED_A.
  - ALLRED_B: if ped_pending -> PED_WALK with next_dir=EW; else -> EW_GREEN.
  - ALLRED_A: if ped_pending -> PED_WALK with next_dir=NS; else -> NS_GREEN.
  - PED_WALK -> NS_GREEN if next_dir=NS, else EW_GREEN.
- Pedestrian latch:
  - ped_pending is set on any cycle with ped_req=1 and state!=PED_WALK.
  - Cleared on the cycle the FSM enters PED_WALK. If ped_req=1 on that same cycle, the clear wins: the request is considered served.
  - ped_req during PED_WALK is ignored.
  - A request never shortens a green; it waits for the next all-red.
- Outputs:
  - Registered, and valid in the cycle after the state register updates (1-cycle latency from phase end to lamp change).
  - ns_light is green only in NS_GREEN and yellow only in NS_YELLOW; red in all other states. ew_light likewise for EW states.
  - walk=1 only in PED_WALK; both directions are red throughout PED_WALK.
  - Safety invariant: no cycle with both ns_light and ew_light non-red; no cycle with walk=1 and any light non-red.
- Reset mid-phase: immediate return to the reset values; any pending request is dropped.
- Width: the timer never underflows; the decrement is gated by timer!=0.

Test Plan:
- Reset release, tick_en tied 1, no ped_req:
  - 3 cycles ALLRED_A, then ns_light=001 for exactly 45 cycles, 010 for 9, then 100.
  - ew green begins 3 cycles later and lasts 45 cycles; full cycle period is 114 cycles, repeating.
- tick_en pulsed 1-in-4:
  - Every phase lasts 4x its tick count (NS green = 180 cycles).
  - phase and timer are frozen between strobes.
- ped_req 1-cycle pulse at cycle 10 of NS_GREEN:
  - ped_pending=1 immediately; NS green still lasts the full 45 ticks.
  - After NS_YELLOW and ALLRED_B: walk=1 for 15 ticks, both lights red, ped_pending=0.
  - Then EW_GREEN.
- ped_req held high continuously:
  - Exactly one walk per all-red; pending re-latches after walk ends.
  - Walk follows every all-red, alternating before NS and EW greens.
- reset asserted low mid EW_YELLOW with ped_pending=1:
  - Outputs go all-red and walk=0 asynchronously; ped_pending=0.
  - After release, sequence restarts from ALLRED_A -> NS_GREEN.
- Throughout all runs:
  - Assertion: never both directions non-red; never walk with a non-red lamp.
  - phase never leaves the range 0-6 for more than 1 cycle.
